// File: rtl/pipelined_tree_multiplier_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipelined_tree_multiplier_if : operand/result handshake bundle (MULT_SIGNED_EN adds in_signed)
// Rev 1.0
// ----------------------------------------------------------------------------
interface pipelined_tree_multiplier_if #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_x;
  logic [WIDTH-1:0]   in_y;
  logic [TAG_W-1:0]   in_tag;
`ifdef MULT_SIGNED_EN
  logic               in_signed;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;
  logic [TAG_W-1:0]   out_tag;
  logic               busy;

`ifdef MULT_SIGNED_EN
  modport master (
    output in_valid, in_x, in_y, in_tag, in_signed, out_ready,
    input  in_ready, out_valid, out_p, out_tag, busy
  );
  modport slave (
    input  in_valid, in_x, in_y, in_tag, in_signed, out_ready,
    output in_ready, out_valid, out_p, out_tag, busy
  );
`else
  modport master (
    output in_valid, in_x, in_y, in_tag, out_ready,
    input  in_ready, out_valid, out_p, out_tag, busy
  );
  modport slave (
    input  in_valid, in_x, in_y, in_tag, out_ready,
    output in_ready, out_valid, out_p, out_tag, busy
  );
`endif
endinterface
`default_nettype wire

// File: rtl/pipelined_tree_multiplier.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipelined_tree_multiplier : 3-stage Dadda-tree multiplier with valid/ready and tag
// Optional signed mode via MULT_SIGNED_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module pipelined_tree_multiplier #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input wire logic                     clk,
  input wire logic                     rst,
  pipelined_tree_multiplier_if.slave   bus
);
  localparam int NC = 2 * WIDTH;
  localparam int MH = WIDTH;
  localparam int c_DADDA [8] = '{2, 3, 4, 6, 9, 13, 19, 28};

  typedef logic [NC-1:0][MH-1:0] cols_t;

  // Partial-product matrix reduced to two rows; signed mode uses modified
  // Baugh-Wooley (inverted edge terms plus constant ones at WIDTH and NC-1).
  function automatic logic [2*NC-1:0] f_dadda(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic             sgn
  );
    cols_t m;
    cols_t nm;
    int    h  [NC];
    int    nh [NC];
    int    idx;
    logic  pp;
    logic  fa_a, fa_b, fa_c;
    m = '0;
    for (int c = 0; c < NC; c++) h[c] = 0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp = x[i] & y[j];
        if (sgn && ((i == WIDTH-1) != (j == WIDTH-1))) pp = ~pp;
        m[i+j][h[i+j]] = pp;
        h[i+j] = h[i+j] + 1;
      end
    end
    m[WIDTH][h[WIDTH]] = sgn;
    h[WIDTH] = h[WIDTH] + 1;
    m[NC-1][h[NC-1]] = sgn;
    h[NC-1] = h[NC-1] + 1;
    for (int s = 7; s >= 0; s--) begin
      if (c_DADDA[s] < MH) begin
        nm = '0;
        for (int c = 0; c < NC; c++) nh[c] = 0;
        for (int c = 0; c < NC; c++) begin
          idx = 0;
          for (int k = 0; k < MH; k++) begin
            if (((h[c] - idx) + nh[c] > c_DADDA[s]) && ((h[c] - idx) >= 2)) begin
              fa_a = m[c][idx];
              fa_b = m[c][idx+1];
              if (((h[c] - idx) + nh[c] == c_DADDA[s] + 1) || ((h[c] - idx) == 2)) begin
                fa_c = 1'b0;
                idx  = idx + 2;
              end else begin
                fa_c = m[c][idx+2];
                idx  = idx + 3;
              end
              nm[c][nh[c]] = fa_a ^ fa_b ^ fa_c;
              nh[c] = nh[c] + 1;
              if (c + 1 < NC) begin
                nm[c+1][nh[c+1]] = (fa_a & fa_b) | (fa_c & (fa_a ^ fa_b));
                nh[c+1] = nh[c+1] + 1;
              end
            end
          end
          for (int k = 0; k < MH; k++) begin
            if (k >= idx && k < h[c]) begin
              nm[c][nh[c]] = m[c][k];
              nh[c] = nh[c] + 1;
            end
          end
        end
        m = nm;
        h = nh;
      end
    end
    for (int c = 0; c < NC; c++) begin
      f_dadda[c]      = m[c][0];
      f_dadda[NC + c] = m[c][1];
    end
  endfunction

  // Kogge-Stone prefix adder; carry out of the top bit is dropped.
  function automatic logic [NC-1:0] f_prefix_add(
    input logic [NC-1:0] a,
    input logic [NC-1:0] b
  );
    logic [NC-1:0] g, p, gn, pn, p0;
    g  = a & b;
    p  = a ^ b;
    p0 = p;
    for (int d = 1; d < NC; d = d * 2) begin
      gn = g;
      pn = p;
      for (int k = d; k < NC; k++) begin
        gn[k] = g[k] | (p[k] & g[k-d]);
        if (k >= 2 * d) pn[k] = p[k] & p[k-d];
      end
      g = gn;
      p = pn;
    end
    f_prefix_add = p0 ^ {g[NC-2:0], 1'b0};
  endfunction

  logic              w_adv0, w_adv1, w_adv2;
  logic              r_v0, r_v1, r_v2;
  logic [WIDTH-1:0]  r_x0, r_y0;
  logic [TAG_W-1:0]  r_tag0, r_tag1, r_tag2;
  logic [NC-1:0]     r_row_a, r_row_b, r_p;
  logic              w_sgn0;
  logic [2*NC-1:0]   w_rows;
  logic [NC-1:0]     w_sum;

`ifdef MULT_SIGNED_EN
  logic              r_sgn0;
  assign w_sgn0 = r_sgn0;
`else
  assign w_sgn0 = 1'b0;
`endif

  assign w_adv2 = !r_v2 || bus.out_ready;
  assign w_adv1 = !r_v1 || w_adv2;
  assign w_adv0 = !r_v0 || w_adv1;

  assign w_rows = f_dadda(r_x0, r_y0, w_sgn0);
  assign w_sum  = f_prefix_add(r_row_a, r_row_b);

  // Data registers only load behind a valid entry so out_p keeps the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v0    <= 1'b0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_x0    <= '0;
      r_y0    <= '0;
      r_tag0  <= '0;
      r_tag1  <= '0;
      r_tag2  <= '0;
      r_row_a <= '0;
      r_row_b <= '0;
      r_p     <= '0;
`ifdef MULT_SIGNED_EN
      r_sgn0  <= 1'b0;
`endif
    end else begin
      if (w_adv0) begin
        r_v0 <= bus.in_valid;
        if (bus.in_valid) begin
          r_x0   <= bus.in_x;
          r_y0   <= bus.in_y;
          r_tag0 <= bus.in_tag;
`ifdef MULT_SIGNED_EN
          r_sgn0 <= bus.in_signed;
`endif
        end
      end
      if (w_adv1) begin
        r_v1 <= r_v0;
        if (r_v0) begin
          r_row_a <= w_rows[NC-1:0];
          r_row_b <= w_rows[2*NC-1:NC];
          r_tag1  <= r_tag0;
        end
      end
      if (w_adv2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_p    <= w_sum;
          r_tag2 <= r_tag1;
        end
      end
    end
  end

  assign bus.in_ready  = w_adv0;
  assign bus.out_valid = r_v2;
  assign bus.out_p     = r_p;
  assign bus.out_tag   = r_tag2;
  assign bus.busy      = r_v0 | r_v1 | r_v2;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_tree_multiplier.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pipelined_tree_multiplier : directed + random stimulus against a queue-based product model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pipelined_tree_multiplier;
  localparam int WIDTH = 8;
  localparam int TAG_W = 4;
  localparam int PW    = 2 * WIDTH;

  typedef struct packed {
    logic [PW-1:0]    p;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic tb_sgn;
  always #5 clk = ~clk;

  pipelined_tree_multiplier_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) u_if ();

  pipelined_tree_multiplier #(.WIDTH(WIDTH), .TAG_W(TAG_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

`ifdef MULT_SIGNED_EN
  assign u_if.in_signed = tb_sgn;
`endif

  exp_t             q[$];
  int               checks = 0;
  int               failures = 0;
  int               n_acc = 0;
  int               n_ret = 0;
  bit               stalled_prev = 0;
  logic [PW-1:0]    held_p;
  logic [TAG_W-1:0] held_tag;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [PW-1:0] ref_mul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                            input logic sgn);
    longint sx, sy;
    if (sgn) begin
      sx = $signed(x);
      sy = $signed(y);
    end else begin
      sx = x;
      sy = y;
    end
    return PW'(sx * sy);
  endfunction

  task automatic drive(input logic v, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic [TAG_W-1:0] t);
    u_if.in_valid = v;
    u_if.in_x     = x;
    u_if.in_y     = y;
    u_if.in_tag   = t;
  endtask

  // One clock: check outputs against the model, then advance across the edge.
  task automatic tick();
    bit   acc;
    bit   ret;
    exp_t e;
    acc = 0;
    ret = 0;
    #1;
    if (!rst) begin
      chk("busy", u_if.busy, q.size() != 0);
      chk("in_ready", u_if.in_ready, (q.size() < 3) || u_if.out_ready);
      if (stalled_prev) begin
        chk("stall_valid", u_if.out_valid, 1'b1);
        chk("stall_p", u_if.out_p, held_p);
        chk("stall_tag", u_if.out_tag, held_tag);
      end
      ret = u_if.out_valid && u_if.out_ready;
      if (ret) begin
        if (q.size() == 0) chk("spurious_out", u_if.out_valid, 1'b0);
        else begin
          e = q.pop_front();
          chk("out_p", u_if.out_p, e.p);
          chk("out_tag", u_if.out_tag, e.tag);
        end
      end
      acc          = u_if.in_valid && u_if.in_ready;
      stalled_prev = u_if.out_valid && !u_if.out_ready;
      held_p       = u_if.out_p;
      held_tag     = u_if.out_tag;
      n_ret        = n_ret + int'(ret);
      n_acc        = n_acc + int'(acc);
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      stalled_prev = 0;
    end else if (acc) begin
      e.p   = ref_mul(u_if.in_x, u_if.in_y, tb_sgn);
      e.tag = u_if.in_tag;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && q.size() > 0; i++) tick();
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    logic [WIDTH-1:0] xs [4];
    logic [WIDTH-1:0] ys [4];
    int r0;
    int a0;
    xs = '{8'd0, 8'd255, 8'd17, 8'd128};
    ys = '{8'd200, 8'd255, 8'd13, 8'd2};
    rst = 1'b1;
    tb_sgn = 1'b0;
    u_if.out_ready = 1'b0;
    drive(1'b0, '0, '0, '0);
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", u_if.out_valid, 1'b0);
    chk("rst_busy", u_if.busy, 1'b0);
    chk("rst_ready", u_if.in_ready, 1'b1);
    chk("rst_p", u_if.out_p, '0);
    chk("rst_tag", u_if.out_tag, '0);

    // single transaction, latency of exactly three cycles
    u_if.out_ready = 1'b1;
    drive(1'b1, 8'd15, 8'd15, 4'd5);
    tick();
    drive(1'b0, '0, '0, '0);
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("lat%0d", k), u_if.out_valid, 64'(k == 3));
      if (k == 3) begin
        chk("single_p", u_if.out_p, 16'd225);
        chk("single_tag", u_if.out_tag, 4'd5);
      end
      tick();
    end
    chk("busy_fall", u_if.busy, 1'b0);

    // back-to-back stream, one result per cycle
    r0 = n_ret;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, xs[i], ys[i], TAG_W'(i + 1));
      tick();
    end
    drive(1'b0, '0, '0, '0);
    for (int i = 0; i < 3; i++) tick();
    chk("b2b_count", n_ret - r0, 4);

    // output stall with continuous input
    u_if.out_ready = 1'b0;
    a0 = n_acc;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, WIDTH'($urandom), WIDTH'($urandom), TAG_W'($urandom));
      tick();
    end
    chk("stall_acc", n_acc - a0, 3);
    drive(1'b0, '0, '0, '0);
    u_if.out_ready = 1'b1;
    drain(20);

    // random traffic
    a0 = n_acc;
    for (int cyc = 0; cyc < 60000 && (n_acc - a0) < 10000; cyc++) begin
      drive(1'($urandom_range(0, 3) != 0), WIDTH'($urandom), WIDTH'($urandom), TAG_W'($urandom));
      u_if.out_ready = 1'($urandom_range(0, 3) != 0);
`ifdef MULT_SIGNED_EN
      tb_sgn = 1'($urandom);
`endif
      tick();
    end
    chk("rand_count", n_acc - a0, 10000);
    drive(1'b0, '0, '0, '0);
    u_if.out_ready = 1'b1;
    drain(20);

`ifdef MULT_SIGNED_EN
    tb_sgn = 1'b1;
    drive(1'b1, 8'h80, 8'd7, 4'd9);
    tick();
    drive(1'b0, '0, '0, '0);
    tick();
    tick();
    chk("signed_p", u_if.out_p, 16'hFC80);
    tick();
    tb_sgn = 1'b0;
    drive(1'b1, 8'h80, 8'd7, 4'd10);
    tick();
    drive(1'b0, '0, '0, '0);
    tick();
    tick();
    chk("unsigned_p", u_if.out_p, 16'h0380);
    tick();
`endif

    // reset with three entries in flight
    u_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, WIDTH'($urandom_range(1, 255)), WIDTH'($urandom_range(1, 255)), TAG_W'(i + 1));
      tick();
    end
    chk("fill_busy", u_if.busy, 1'b1);
    rst = 1'b1;
    drive(1'b1, 8'd99, 8'd99, 4'd7);
    tick();
    rst = 1'b0;
    drive(1'b0, '0, '0, '0);
    u_if.out_ready = 1'b1;
    chk("rst2_ready", u_if.in_ready, 1'b1);
    chk("rst2_valid", u_if.out_valid, 1'b0);
    chk("rst2_p", u_if.out_p, '0);
    chk("rst2_tag", u_if.out_tag, '0);
    for (int i = 0; i < 5; i++) begin
      chk("rst2_quiet", u_if.out_valid, 1'b0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_tree_multiplier.md
Name: pipelined_tree_multiplier

Overview:
- Parametrised, pipelined unsigned integer multiplier. Generalises the team's combinational 4x4 partial-product-tree multiplier.
- Generation, reduction and final addition are split into three registered stages. A valid/ready handshake with full backpressure surrounds them.
- Carries a sideband tag so downstream logic can match results to requests.
- Sits between an operand-issuing datapath and a result consumer that may stall.

Parameters:
- WIDTH, 8: operand width in bits, legal range 2..32. Result width is 2*WIDTH.
- TAG_W, 4: width of the sideband tag carried alongside each operand pair, legal range 1..16.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair and tag presented.
- in_ready  output  1  block accepts the pair this cycle.
- in_x  input  WIDTH  multiplicand.
- in_y  input  WIDTH  multiplier.
- in_tag  input  TAG_W  sideband tag, passed through unchanged.
- out_valid  output  1  result presented.
- out_ready  input  1  consumer accepts the result this cycle.
- out_p  output  2*WIDTH  product.
- out_tag  output  TAG_W  tag of the product on out_p.
- busy  output  1  at least one stage holds a valid entry.

Behaviour:
- Three pipeline stages S0, S1, S2, each with a valid bit v0, v1, v2.
- S0: registers x, y and tag on an accepted input (in_valid & in_ready).
- S1: forms WIDTH*WIDTH AND partial products from the S0 registers. Reduces them with half/full adders (Dadda schedule) to two rows of 2*WIDTH bits, then registers the rows and the tag.
- S2: adds the two rows with a parallel-prefix adder (generate/propagate, black/grey cells). Registers the 2*WIDTH sum and the tag. S2 drives out_p and out_tag directly.
- Latency: an input accepted in cycle N appears on out_valid/out_p in cycle N+3 when not stalled. Throughput is one result per cycle.
- Advance rules:
  - adv2 = !v2 | out_ready
  - adv1 = !v1 | adv2
  - adv0 = !v0 | adv1
  - in_ready = adv0
- Per-stage update:
  - When adv_k is set, stage k loads from its predecessor, including the valid bit.
  - When adv_k is clear, stage k holds all its registers.
- A stalled stage keeps its data stable. out_p and out_tag must not change while out_valid & !out_ready.
- Transfer occurs only on valid & ready. Inputs presented while in_ready=0 are ignored and must not corrupt state.
- Simultaneous events:
  - Full pipeline (v0=v1=v2=1) with out_ready=1: accept and retire in the same cycle; occupancy stays at 3.
  - Full pipeline with out_ready=0: in_ready=0 combinationally in the same cycle.
- Bubbles collapse: an empty stage accepts from its predecessor even when downstream is stalled.
- out_valid = v2. busy = v0 | v1 | v2.
- Width rules: the product is exact; no truncation or overflow is possible.
  - Partial product of x[i] and y[j] has weight i+j.
  - Prefix-adder carry-out of bit 2*WIDTH-1 is discarded; it is provably zero for unsigned operands.
- Reset (synchronous, active-high):
  - v0, v1, v2 clear; out_valid=0; busy=0; in_ready=1 in the cycle after reset deasserts.
  - out_p and out_tag reset to 0. Data registers of S0 and S1 also reset to 0.
- Reset mid-operation: every in-flight entry is discarded and no result is emitted for it. An input offered during reset is not accepted.

Optional Feature:
- Macro: MULT_SIGNED_EN.
- When defined:
  - Adds input port in_signed (1 bit), sampled with the operands and carried through the pipeline with the tag.
  - When in_signed=1, operands are two's complement and the product is the exact two's-complement 2*WIDTH result (modified Baugh-Wooley partial products with constant correction bits).
  - When in_signed=0, behaviour is identical to unsigned.
- When not defined: the in_signed port does not exist and all operands are unsigned.
- Latency and handshake are the same in both builds.

Test Plan:
- WIDTH=4, single transaction x=15, y=15, tag=5, out_ready=1 -> out_valid exactly 3 cycles after accept; out_p=225 (0x00E1); out_tag=5; busy then falls.
- WIDTH=8, back-to-back stream (0,200), (255,255), (17,13), (128,2), one per cycle, out_ready=1 -> results 0, 65025, 221, 256 on consecutive cycles in order with matching tags; in_ready held at 1.
- WIDTH=8, continuous input, out_ready held 0 for 6 cycles -> exactly 3 inputs accepted; in_ready=0 from the fourth; out_p/out_tag stable throughout. After release, all results drain in order with no loss or duplication.
- WIDTH=8, random operands with random in_valid/out_ready (10k transactions) compared against a golden scoreboard -> zero mismatches; in_ready never 1 while full and stalled.
- Three entries in flight, rst pulsed for 1 cycle -> no out_valid afterwards for those entries; out_p=0; in_ready=1 the cycle after reset.
- MULT_SIGNED_EN build, WIDTH=4: x=-8 (0x8), y=7, in_signed=1 -> out_p=0xC8 (-56). Same operands with in_signed=0 -> out_p=0x38 (56).
